// File: rtl/harvard_avalon_bridge.sv
// -----------------------------------------------------------------------------
// harvard_avalon_bridge
//
// Lets a Harvard-style CPU (separate instruction and data ports) run from a
// single Avalon-MM master port. The CPU is single-stepped through its
// clk_enable: each instruction is fetched, optionally followed by one data
// read or write, and then the CPU is allowed exactly one clock to retire it.
//
// Ports
//   clk, reset          sole clock; asynchronous active-low reset
//   enable              host run-enable (sampled in IDLE and at end of STEP)
//   cpu_active          CPU still running; low at end of STEP stops the bridge
//   cpu_clk_enable      one-cycle pulse per retired instruction
//   instr_address       CPU fetch address
//   instr_readdata      latched instruction word
//   data_address        CPU data address
//   data_writedata      CPU store word (already byte-merged by the CPU)
//   data_read/write     CPU data strobes, decoded from instr_readdata
//   data_readdata       latched load word
//   avm_*               Avalon-MM master (word-aligned, full-word accesses)
//   busy                high whenever the bridge is not IDLE
// -----------------------------------------------------------------------------
module harvard_avalon_bridge (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        cpu_active,
   output logic        cpu_clk_enable,
   input  logic [31:0] instr_address,
   output logic [31:0] instr_readdata,
   input  logic [31:0] data_address,
   input  logic [31:0] data_writedata,
   input  logic        data_read,
   input  logic        data_write,
   output logic [31:0] data_readdata,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECIDE,
      S_DREAD,
      S_DWRITE,
      S_STEP
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_instr;
   logic [31:0] r_data;

   // Byte lanes are the CPU's concern; the bus only ever sees whole words.
   logic w_unused_addr_bits;
   assign w_unused_addr_bits = &{1'b0, instr_address[1:0], data_address[1:0]};

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // NOTE: these are plain registers, not memories, so they take the async
   // reset; a reset mid-transfer therefore never leaves a partial latch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_instr <= '0;
         r_data  <= '0;
      end else begin
         if (r_state == S_FETCH && !avm_waitrequest) begin
            r_instr <= avm_readdata;
         end
         if (r_state == S_DREAD && !avm_waitrequest) begin
            r_data <= avm_readdata;
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      w_next         = r_state;
      avm_read       = 1'b0;
      avm_write      = 1'b0;
      cpu_clk_enable = 1'b0;
      avm_address    = {instr_address[31:2], 2'b00};

      case (r_state)
         S_IDLE: begin
            if (enable) w_next = S_FETCH;
         end
         S_FETCH: begin
            avm_read = 1'b1;
            if (!avm_waitrequest) w_next = S_DECIDE;
         end
         // The CPU's data strobes are decoded from the freshly latched word,
         // so they are only trusted here. A store wins over a load.
         S_DECIDE: begin
            if (data_write)     w_next = S_DWRITE;
            else if (data_read) w_next = S_DREAD;
            else                w_next = S_STEP;
         end
         S_DREAD: begin
            avm_read    = 1'b1;
            avm_address = {data_address[31:2], 2'b00};
            if (!avm_waitrequest) w_next = S_STEP;
         end
         S_DWRITE: begin
            avm_write   = 1'b1;
            avm_address = {data_address[31:2], 2'b00};
            if (!avm_waitrequest) w_next = S_STEP;
         end
         // The run-enable is only honoured here, so dropping it never aborts
         // an instruction part-way through.
         S_STEP: begin
            cpu_clk_enable = 1'b1;
            w_next = (enable && cpu_active) ? S_FETCH : S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   assign busy           = (r_state != S_IDLE);
   assign avm_writedata  = data_writedata;
   assign avm_byteenable = 4'hF;
   assign instr_readdata = r_instr;
   assign data_readdata  = r_data;

endmodule
